// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM between a serial loader and N_PORTS CPU-side
//   requesters. LOAD_MODE=1 hands the SRAM exclusively to the loader;
//   otherwise the CPU ports are served round-robin. Read data comes back
//   RD_LAT+1 cycles after the grant on the shared rdata bus, qualified by a
//   one-cycle rvalid strobe to the port that issued the read.
//
// Handshake: req/gnt only. A requester holds req; the access is taken in any
//   cycle where its gnt is 1 (gnt is combinational, same cycle). The requester
//   then drops or changes req on the next cycle. There is no other back-pressure.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   LOAD_MODE           1 = loader owns the SRAM
//   ld_req/we/addr/wdata, ld_gnt, ld_rvalid         loader port
//   cpu_req/we/addr/wdata, cpu_gnt, cpu_rvalid      packed CPU ports
//   rdata               shared read data
//   CEN, WEN, A, D, Q   SRAM pins (CEN/WEN active-low)
module sram_port_arbiter #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int N_PORTS = 2,
  parameter int RD_LAT  = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      LOAD_MODE,
  input  logic                      ld_req,
  input  logic                      ld_we,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]         ld_wdata,
  output logic                      ld_gnt,
  output logic                      ld_rvalid,
  input  logic [N_PORTS-1:0]        cpu_req,
  input  logic [N_PORTS-1:0]        cpu_we,
  input  logic [N_PORTS*ADDR_W-1:0] cpu_addr,
  input  logic [N_PORTS*DATA_W-1:0] cpu_wdata,
  output logic [N_PORTS-1:0]        cpu_gnt,
  output logic [N_PORTS-1:0]        cpu_rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      CEN,
  output logic                      WEN,
  output logic [ADDR_W-1:0]         A,
  output logic [DATA_W-1:0]         D,
  input  logic [DATA_W-1:0]         Q
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // Read tag travelling alongside the SRAM access.
  typedef struct packed {
    logic             valid;
    logic             ld;
    logic [PTR_W-1:0] port;
  } tag_t;

  logic [PTR_W-1:0] rr_ptr;
  logic             cpu_any;
  logic [PTR_W-1:0] win;
  logic             cpu_grant;
  tag_t             new_tag;
  tag_t             pipe [RD_LAT];
  tag_t             out_tag;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    cpu_any = 1'b0;
    win     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % N_PORTS;
      if (!cpu_any && cpu_req[idx]) begin
        cpu_any = 1'b1;
        win     = PTR_W'(idx);
      end
    end
  end

  // Grants and SRAM drive; everything idles while RST is high.
  always_comb begin
    ld_gnt    = !RST && LOAD_MODE && ld_req;
    cpu_grant = !RST && !LOAD_MODE && cpu_any;
    cpu_gnt   = cpu_grant ? (N_PORTS'(1) << win) : '0;
    CEN       = 1'b1;
    WEN       = 1'b1;
    A         = '0;
    D         = '0;
    new_tag   = '0;
    if (ld_gnt) begin
      CEN           = 1'b0;
      WEN           = !ld_we;
      A             = ld_addr;
      D             = ld_wdata;
      new_tag.valid = !ld_we;
      new_tag.ld    = 1'b1;
    end else if (cpu_grant) begin
      CEN           = 1'b0;
      WEN           = !cpu_we[win];
      A             = cpu_addr[win*ADDR_W +: ADDR_W];
      D             = cpu_wdata[win*DATA_W +: DATA_W];
      new_tag.valid = !cpu_we[win];
      new_tag.port  = win;
    end
  end

  assign out_tag = pipe[RD_LAT-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr     <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      ld_rvalid  <= 1'b0;
      cpu_rvalid <= '0;
      rdata      <= '0;
    end else begin
      if (cpu_grant)
        rr_ptr <= (win == PTR_W'(N_PORTS - 1)) ? '0 : win + 1'b1;
      pipe[0] <= new_tag;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      // Tag emerges in the same cycle Q is valid; register both together.
      ld_rvalid  <= out_tag.valid && out_tag.ld;
      cpu_rvalid <= (out_tag.valid && !out_tag.ld) ? (N_PORTS'(1) << out_tag.port) : '0;
      if (out_tag.valid) rdata <= Q;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter. Two instances share the same
//   stimulus: dut_a with RD_LAT=1 and dut_b with RD_LAT=3, each with its own
//   SRAM read model whose contents come from sram_val().
module tb_sram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        LOAD_MODE;
  logic        ld_req, ld_we;
  logic [8:0]  ld_addr;
  logic [7:0]  ld_wdata;
  logic [1:0]  cpu_req, cpu_we;
  logic [17:0] cpu_addr;
  logic [15:0] cpu_wdata;

  logic        a_ld_gnt, a_ld_rvalid, a_CEN, a_WEN;
  logic [1:0]  a_cpu_gnt, a_cpu_rvalid;
  logic [7:0]  a_rdata, a_D;
  logic [8:0]  a_A;
  logic [7:0]  a_Q = 8'h00;

  logic        b_ld_gnt, b_ld_rvalid, b_CEN, b_WEN;
  logic [1:0]  b_cpu_gnt, b_cpu_rvalid;
  logic [7:0]  b_rdata, b_D;
  logic [8:0]  b_A;
  logic [7:0]  b_q0 = 8'h00, b_q1 = 8'h00, b_Q = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset block
  always #5 CLK = ~CLK;

  sram_port_arbiter #(.DATA_W(8), .ADDR_W(9), .N_PORTS(2), .RD_LAT(1)) dut_a (
    .CLK(CLK), .RST(RST), .LOAD_MODE(LOAD_MODE),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(a_ld_gnt), .ld_rvalid(a_ld_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .rdata(a_rdata),
    .CEN(a_CEN), .WEN(a_WEN), .A(a_A), .D(a_D), .Q(a_Q)
  );

  sram_port_arbiter #(.DATA_W(8), .ADDR_W(9), .N_PORTS(2), .RD_LAT(3)) dut_b (
    .CLK(CLK), .RST(RST), .LOAD_MODE(LOAD_MODE),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(b_ld_gnt), .ld_rvalid(b_ld_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .rdata(b_rdata),
    .CEN(b_CEN), .WEN(b_WEN), .A(b_A), .D(b_D), .Q(b_Q)
  );

  // SRAM contents: a few fixed words, everything else addr ^ 5A.
  function automatic logic [7:0] sram_val(input logic [8:0] addr);
    case (addr)
      9'h1A5:  return 8'h3C;
      9'h000:  return 8'h77;
      default: return addr[7:0] ^ 8'h5A;
    endcase
  endfunction

  // SRAM read models: 1-cycle and 3-cycle clock-to-Q.
  always @(posedge CLK) begin
    if (!a_CEN) a_Q <= sram_val(a_A);
    if (!b_CEN) b_q0 <= sram_val(b_A);
    b_q1 <= b_q0;
    b_Q  <= b_q1;
  end

  // Driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    LOAD_MODE = 1'b0;
    ld_req    = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = 9'h000;
    ld_wdata  = 8'h00;
    cpu_req   = 2'b00;
    cpu_we    = 2'b00;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic flush();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    RST     = 1'b1;
    ld_req  = 1'b1;
    cpu_req = 2'b11;
    step();
    for (int i = 0; i < 3; i++) begin
      LOAD_MODE = (i == 1);
      #2;
      n_cmp++;
      if ({a_ld_gnt, a_cpu_gnt, a_CEN, a_WEN, a_A, a_D} !== {1'b0, 2'b00, 1'b1, 1'b1, 9'h000, 8'h00}) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: got gnt=%b/%b CEN=%b WEN=%b A=%h D=%h, need all idle",
                 i, a_ld_gnt, a_cpu_gnt, a_CEN, a_WEN, a_A, a_D);
      end
      n_cmp++;
      if ({a_ld_rvalid, a_cpu_rvalid, a_rdata, b_ld_rvalid, b_cpu_rvalid} !== 14'h0) begin
        n_err++;
        $display("FAIL reset_regs cyc%0d: got rv=%b/%b rdata=%h brv=%b/%b, need 0",
                 i, a_ld_rvalid, a_cpu_rvalid, a_rdata, b_ld_rvalid, b_cpu_rvalid);
      end
      step();
    end
    RST       = 1'b0;
    LOAD_MODE = 1'b0;
    ld_req    = 1'b0;
    #2;
    n_cmp++;
    if ({a_cpu_gnt, a_CEN} !== {2'b01, 1'b0}) begin
      n_err++;
      $display("FAIL reset_first_grant: got cpu_gnt=%b CEN=%b, need 01 0", a_cpu_gnt, a_CEN);
    end
    step();
    flush();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [8:0] exp_a;
    idle_inputs();
    RST = 1'b1;
    step();
    RST      = 1'b0;
    cpu_req  = 2'b11;
    cpu_addr = {9'h122, 9'h011};
    for (int i = 0; i < 6; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a   = (i % 2 == 0) ? 9'h011 : 9'h122;
      #2;
      n_cmp++;
      if ({a_cpu_gnt, a_ld_gnt, a_CEN, a_WEN, a_A} !== {exp_gnt, 1'b0, 1'b0, 1'b1, exp_a}) begin
        n_err++;
        $display("FAIL rr_cyc%0d: got gnt=%b CEN=%b WEN=%b A=%h, need gnt=%b CEN=0 WEN=1 A=%h",
                 i, a_cpu_gnt, a_CEN, a_WEN, a_A, exp_gnt, exp_a);
      end
      step();
    end
    flush();
  endtask

  task automatic test_read_latency();
    idle_inputs();
    cpu_req  = 2'b10;
    cpu_addr = {9'h1A5, 9'h000};
    #2;
    n_cmp++;
    if ({a_cpu_gnt, a_CEN, a_WEN, a_A} !== {2'b10, 1'b0, 1'b1, 9'h1A5}) begin
      n_err++;
      $display("FAIL rd_grant: got gnt=%b CEN=%b WEN=%b A=%h, need 10 0 1 1a5",
               a_cpu_gnt, a_CEN, a_WEN, a_A);
    end
    step();
    idle_inputs();
    #2;
    n_cmp++;
    if ({a_cpu_rvalid, a_ld_rvalid} !== 3'b000) begin
      n_err++;
      $display("FAIL rd_early: got rvalid=%b/%b one cycle after grant, need 0", a_cpu_rvalid, a_ld_rvalid);
    end
    step();
    #2;
    n_cmp++;
    if ({a_cpu_rvalid, a_ld_rvalid, a_rdata} !== {2'b10, 1'b0, 8'h3C}) begin
      n_err++;
      $display("FAIL rd_return: got rvalid=%b ld=%b rdata=%h, need 10 0 3c",
               a_cpu_rvalid, a_ld_rvalid, a_rdata);
    end
    step();
    #2;
    n_cmp++;
    if ({a_cpu_rvalid, a_rdata} !== {2'b00, 8'h3C}) begin
      n_err++;
      $display("FAIL rd_hold: got rvalid=%b rdata=%h, need 00 3c", a_cpu_rvalid, a_rdata);
    end
    flush();
  endtask

  task automatic test_write();
    idle_inputs();
    cpu_req   = 2'b01;
    cpu_we    = 2'b01;
    cpu_addr  = {9'h000, 9'h010};
    cpu_wdata = {8'h00, 8'hA5};
    #2;
    n_cmp++;
    if ({a_cpu_gnt, a_CEN, a_WEN, a_A, a_D} !== {2'b01, 1'b0, 1'b0, 9'h010, 8'hA5}) begin
      n_err++;
      $display("FAIL wr_pins: got gnt=%b CEN=%b WEN=%b A=%h D=%h, need 01 0 0 010 a5",
               a_cpu_gnt, a_CEN, a_WEN, a_A, a_D);
    end
    step();
    idle_inputs();
    for (int i = 1; i <= 5; i++) begin
      #2;
      n_cmp++;
      if ({a_cpu_rvalid, a_ld_rvalid, b_cpu_rvalid, b_ld_rvalid} !== 6'b0) begin
        n_err++;
        $display("FAIL wr_no_rvalid cyc%0d: got a=%b/%b b=%b/%b, need 0",
                 i, a_cpu_rvalid, a_ld_rvalid, b_cpu_rvalid, b_ld_rvalid);
      end
      step();
    end
    flush();
  endtask

  task automatic test_loader();
    idle_inputs();
    LOAD_MODE = 1'b1;
    ld_req    = 1'b1;
    ld_addr   = 9'h000;
    cpu_req   = 2'b11;
    #2;
    n_cmp++;
    if ({a_ld_gnt, a_cpu_gnt, a_CEN, a_WEN, a_A} !== {1'b1, 2'b00, 1'b0, 1'b1, 9'h000}) begin
      n_err++;
      $display("FAIL ld_excl: got ld_gnt=%b cpu_gnt=%b CEN=%b WEN=%b A=%h, need 1 00 0 1 000",
               a_ld_gnt, a_cpu_gnt, a_CEN, a_WEN, a_A);
    end
    step();
    // Loader write in the following cycle.
    ld_we    = 1'b1;
    ld_addr  = 9'h055;
    ld_wdata = 8'h99;
    #2;
    n_cmp++;
    if ({a_ld_gnt, a_cpu_gnt, a_CEN, a_WEN, a_A, a_D, a_ld_rvalid} !==
        {1'b1, 2'b00, 1'b0, 1'b0, 9'h055, 8'h99, 1'b0}) begin
      n_err++;
      $display("FAIL ld_write: got ld_gnt=%b cpu_gnt=%b CEN=%b WEN=%b A=%h D=%h rv=%b, need 1 00 0 0 055 99 0",
               a_ld_gnt, a_cpu_gnt, a_CEN, a_WEN, a_A, a_D, a_ld_rvalid);
    end
    step();
    ld_req = 1'b0;
    #2;
    n_cmp++;
    if ({a_ld_rvalid, a_cpu_rvalid, a_rdata} !== {1'b1, 2'b00, 8'h77}) begin
      n_err++;
      $display("FAIL ld_return: got ld_rvalid=%b cpu_rvalid=%b rdata=%h, need 1 00 77",
               a_ld_rvalid, a_cpu_rvalid, a_rdata);
    end
    step();
    #2;
    n_cmp++;
    if (a_ld_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ld_write_no_rvalid: got ld_rvalid=%b, need 0", a_ld_rvalid);
    end
    flush();
  endtask

  task automatic test_mode_switch();
    logic [1:0] exp_rv;
    idle_inputs();
    cpu_req  = 2'b01;
    cpu_addr = {9'h000, 9'h033};
    #2;
    n_cmp++;
    if ({b_cpu_gnt, b_CEN, b_A} !== {2'b01, 1'b0, 9'h033}) begin
      n_err++;
      $display("FAIL ms_grant: got gnt=%b CEN=%b A=%h, need 01 0 033", b_cpu_gnt, b_CEN, b_A);
    end
    step();
    LOAD_MODE = 1'b1;
    ld_req    = 1'b1;
    ld_we     = 1'b1;
    ld_addr   = 9'h100;
    #2;
    n_cmp++;
    if ({b_ld_gnt, b_cpu_gnt} !== {1'b1, 2'b00}) begin
      n_err++;
      $display("FAIL ms_switch: got ld_gnt=%b cpu_gnt=%b, need 1 00", b_ld_gnt, b_cpu_gnt);
    end
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) #2;
      exp_rv = (c == 4) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({b_cpu_rvalid, b_ld_rvalid} !== {exp_rv, 1'b0}) begin
        n_err++;
        $display("FAIL ms_rvalid g+%0d: got cpu=%b ld=%b, need cpu=%b ld=0", c, b_cpu_rvalid, b_ld_rvalid, exp_rv);
      end
      if (c == 4) begin
        n_cmp++;
        if (b_rdata !== 8'h69) begin
          n_err++;
          $display("FAIL ms_rdata: got %h, need 69", b_rdata);
        end
      end
      step();
      ld_req = 1'b0;
      cpu_req = 2'b00;
    end
    flush();

    // Repeat with RST pulsed two cycles after the grant: the read is dropped.
    cpu_req  = 2'b01;
    cpu_addr = {9'h000, 9'h033};
    step();
    cpu_req   = 2'b00;
    LOAD_MODE = 1'b1;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      #2;
      n_cmp++;
      if ({b_cpu_rvalid, b_ld_rvalid} !== 3'b000) begin
        n_err++;
        $display("FAIL ms_rst_drop g+%0d: got cpu=%b ld=%b, need 0", c, b_cpu_rvalid, b_ld_rvalid);
      end
      step();
    end
    flush();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    test_reset();
    test_round_robin();
    test_read_latency();
    test_write();
    test_loader();
    test_mode_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
